// File: rtl/pulse_width_capture.sv
// Measures high-time of NUM_CH asynchronous pulses, quantises each width to an 8-bit bin and
// writes one {ch, bin} packet per completed pulse into the histogram FIFO.
module pulse_width_capture #(
   parameter int NUM_CH     = 2,
   parameter int CNT_WIDTH  = 24,
   parameter int SHIFT_BITS = 2,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_CH-1:0]     pulse_in,
   input  logic                  bram_reset_done,
   output logic                  wrreq_to_FIFO,
   output logic [DATA_WIDTH-1:0] data_packet_to_FIFO,
   input  logic                  wrfull_from_FIFO,
   output logic [15:0]           drop_count
);

   typedef enum logic [1:0] {
      DISARMED  = 2'd0,
      WAIT_RISE = 2'd1,
      MEASURE   = 2'd2
   } ch_state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] BIN_MAX = CNT_WIDTH'(255);

   ch_state_e               state_r [NUM_CH];
   logic [CNT_WIDTH-1:0]    cnt_r   [NUM_CH];
   logic [7:0]              bin_r   [NUM_CH];
   logic [NUM_CH-1:0]       sync1_r;
   logic [NUM_CH-1:0]       sync2_r;
   logic [NUM_CH-1:0]       prev_r;
   logic [NUM_CH-1:0]       pending_r;
   logic [1:0]              settle_r;
   logic                    rr_ptr_r;
   logic                    wrreq_r;
   logic [DATA_WIDTH-1:0]   data_r;
   logic [15:0]             drop_count_r;

   logic [NUM_CH-1:0]       rise_s;
   logic [NUM_CH-1:0]       fall_s;
   logic [NUM_CH-1:0]       latch_s;
   logic [NUM_CH-1:0]       drop_s;
   logic                    grant_s;
   logic                    grant_ch_s;
   logic [16:0]             drop_sum_s;
   logic [15:0]             drop_next_s;

   function automatic logic [7:0] quantise(input logic [CNT_WIDTH-1:0] cnt);
      logic [CNT_WIDTH-1:0] shifted;
      shifted = cnt >> SHIFT_BITS;
      if (shifted > BIN_MAX) begin
         return 8'hFF;
      end else begin
         return shifted[7:0];
      end
   endfunction

   // Edge decode on the synchronised level and per-channel latch/drop qualification.
   always_comb begin
      rise_s  = sync2_r & ~prev_r;
      fall_s  = ~sync2_r & prev_r;
      latch_s = '0;
      drop_s  = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         latch_s[ch] = bram_reset_done && (state_r[ch] == MEASURE) && fall_s[ch];
         drop_s[ch]  = latch_s[ch] && pending_r[ch];
      end
   end

   // Two-channel write arbiter: lone requester wins, ties go to rr_ptr.
   always_comb begin
      grant_s    = 1'b0;
      grant_ch_s = 1'b0;
      if (bram_reset_done && !wrfull_from_FIFO && (|pending_r)) begin
         grant_s = 1'b1;
         if (&pending_r) begin
            grant_ch_s = rr_ptr_r;
         end else begin
            grant_ch_s = pending_r[1];
         end
      end else begin
         grant_s    = 1'b0;
         grant_ch_s = 1'b0;
      end
   end

   // Saturating accumulation of dropped results (both channels may drop together).
   always_comb begin
      drop_sum_s = {1'b0, drop_count_r} + {16'd0, drop_s[0]} + {16'd0, drop_s[1]};
      if (drop_sum_s[16]) begin
         drop_next_s = 16'hFFFF;
      end else begin
         drop_next_s = drop_sum_s[15:0];
      end
   end

   // Synchroniser, channel FSMs, pending slots and counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r      <= '0;
         sync2_r      <= '0;
         prev_r       <= '0;
         pending_r    <= '0;
         settle_r     <= 2'b00;
         drop_count_r <= 16'd0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            state_r[ch] <= DISARMED;
            cnt_r[ch]   <= '0;
            bin_r[ch]   <= 8'd0;
         end
      end else begin
         sync1_r      <= pulse_in;
         sync2_r      <= sync1_r;
         prev_r       <= sync2_r;
         // Arming waits until the synchroniser holds real pin values after reset.
         settle_r     <= {settle_r[0], 1'b1};
         drop_count_r <= drop_next_s;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!bram_reset_done) begin
               state_r[ch]   <= DISARMED;
               cnt_r[ch]     <= '0;
               pending_r[ch] <= 1'b0;
            end else begin
               case (state_r[ch])
                  DISARMED: begin
                     cnt_r[ch] <= '0;
                     if (settle_r[1] && !sync2_r[ch]) begin
                        state_r[ch] <= WAIT_RISE;
                     end
                  end
                  WAIT_RISE: begin
                     if (rise_s[ch]) begin
                        state_r[ch] <= MEASURE;
                        cnt_r[ch]   <= CNT_ONE;
                     end
                  end
                  MEASURE: begin
                     if (sync2_r[ch]) begin
                        if (cnt_r[ch] != CNT_MAX) begin
                           cnt_r[ch] <= cnt_r[ch] + CNT_ONE;
                        end
                     end else begin
                        state_r[ch] <= WAIT_RISE;
                     end
                  end
                  default: begin
                     state_r[ch] <= DISARMED;
                     cnt_r[ch]   <= '0;
                  end
               endcase
               if (latch_s[ch] && !pending_r[ch]) begin
                  pending_r[ch] <= 1'b1;
                  bin_r[ch]     <= quantise(cnt_r[ch]);
               end else if (grant_s && (grant_ch_s == ch[0])) begin
                  pending_r[ch] <= 1'b0;
               end
            end
         end
      end
   end

   // Registered FIFO write port and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrreq_r  <= 1'b0;
         data_r   <= '0;
         rr_ptr_r <= 1'b0;
      end else begin
         wrreq_r <= grant_s;
         if (grant_s) begin
            data_r <= {{(DATA_WIDTH-9){1'b0}}, grant_ch_s, bin_r[grant_ch_s]};
            if (&pending_r) begin
               rr_ptr_r <= ~rr_ptr_r;
            end
         end
      end
   end

   assign wrreq_to_FIFO       = wrreq_r;
   assign data_packet_to_FIFO = data_r;
   assign drop_count          = drop_count_r;

endmodule

// File: tb/tb_pulse_width_capture.sv
// Directed bench for pulse_width_capture: captures every FIFO write and checks packets,
// ordering, drop counting, enable gating and asynchronous reset.
module tb_pulse_width_capture;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  pulse_in = 2'b00;
   logic        bram_reset_done = 1'b0;
   logic        wrfull_from_FIFO = 1'b0;
   logic        wrreq_to_FIFO;
   logic [15:0] data_packet_to_FIFO;
   logic [15:0] drop_count;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   logic [15:0] pkt_q[$];
   int          stamp_q[$];

   pulse_width_capture dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .pulse_in            (pulse_in),
      .bram_reset_done     (bram_reset_done),
      .wrreq_to_FIFO       (wrreq_to_FIFO),
      .data_packet_to_FIFO (data_packet_to_FIFO),
      .wrfull_from_FIFO    (wrfull_from_FIFO),
      .drop_count          (drop_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record each FIFO write with the cycle it occurred in.
   always @(negedge clk) begin
      if (reset_n && wrreq_to_FIFO) begin
         pkt_q.push_back(data_packet_to_FIFO);
         stamp_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch, input int n);
      pulse_in[ch] = 1'b1;
      tick(n);
      pulse_in[ch] = 1'b0;
   endtask

   task automatic flush();
      pkt_q.delete();
      stamp_q.delete();
   endtask

   function automatic logic [31:0] pkt(input int i);
      if (i < pkt_q.size()) return {16'd0, pkt_q[i]};
      else return 32'hFFFF_FFFF;
   endfunction

   function automatic int stamp(input int i);
      if (i < stamp_q.size()) return stamp_q[i];
      else return -100;
   endfunction

   task automatic tie(input string tag, input logic [15:0] first, input logic [15:0] second);
      pulse_in[1] = 1'b1;
      tick(4);
      pulse_in[0] = 1'b1;
      tick(8);
      pulse_in = 2'b00;
      tick(10);
      check({tag, "_count"}, 32'(pkt_q.size()), 32'd2);
      check({tag, "_first"}, pkt(0), {16'd0, first});
      check({tag, "_second"}, pkt(1), {16'd0, second});
      check({tag, "_back_to_back"}, 32'(stamp(1) - stamp(0)), 32'd1);
      flush();
   endtask

   initial begin
      tick(3);
      check("rst_wrreq", {31'd0, wrreq_to_FIFO}, 32'd0);
      check("rst_data", {16'd0, data_packet_to_FIFO}, 32'd0);
      check("rst_drop", {16'd0, drop_count}, 32'd0);
      reset_n = 1'b1;
      tick(2);
      bram_reset_done = 1'b1;
      tick(5);

      // 40 cycles -> bin 10 on ch0
      pulse(0, 40);
      tick(10);
      check("t1_count", 32'(pkt_q.size()), 32'd1);
      check("t1_pkt", pkt(0), 32'h000A);
      check("t1_drop", {16'd0, drop_count}, 32'd0);
      flush();

      // 5000 cycles -> saturated bin on ch1
      pulse(1, 5000);
      tick(10);
      check("t2_count", 32'(pkt_q.size()), 32'd1);
      check("t2_pkt", pkt(0), 32'h01FF);
      flush();

      // simultaneous falls: ch0 first, then the next tie serves ch1 first
      tie("t3a", 16'h0002, 16'h0103);
      tie("t3b", 16'h0103, 16'h0002);

      // back-pressure: first result held, two later ones dropped
      wrfull_from_FIFO = 1'b1;
      tick(2);
      repeat (3) begin
         pulse(0, 16);
         tick(4);
      end
      tick(6);
      check("t4_blocked", 32'(pkt_q.size()), 32'd0);
      check("t4_drop", {16'd0, drop_count}, 32'd2);
      wrfull_from_FIFO = 1'b0;
      tick(6);
      check("t4_count", 32'(pkt_q.size()), 32'd1);
      check("t4_pkt", pkt(0), 32'h0004);
      check("t4_idle_wrreq", {31'd0, wrreq_to_FIFO}, 32'd0);
      check("t4_hold_data", {16'd0, data_packet_to_FIFO}, 32'h0004);
      flush();

      // pulse already high at enable is skipped
      bram_reset_done = 1'b0;
      tick(3);
      pulse_in[0] = 1'b1;
      tick(5);
      bram_reset_done = 1'b1;
      tick(30);
      pulse_in[0] = 1'b0;
      tick(10);
      check("t5_skipped", 32'(pkt_q.size()), 32'd0);
      pulse(0, 20);
      tick(10);
      check("t5_count", 32'(pkt_q.size()), 32'd1);
      check("t5_pkt", pkt(0), 32'h0005);
      flush();

      // async reset in the middle of a pulse
      pulse_in[0] = 1'b1;
      tick(10);
      reset_n = 1'b0;
      #1;
      check("t6_rst_wrreq", {31'd0, wrreq_to_FIFO}, 32'd0);
      check("t6_rst_data", {16'd0, data_packet_to_FIFO}, 32'd0);
      check("t6_rst_drop", {16'd0, drop_count}, 32'd0);
      tick(1);
      reset_n = 1'b1;
      tick(10);
      pulse_in[0] = 1'b0;
      tick(10);
      check("t6_cut_pulse", 32'(pkt_q.size()), 32'd0);
      pulse(1, 24);
      tick(10);
      check("t6_count", 32'(pkt_q.size()), 32'd1);
      check("t6_pkt", pkt(0), 32'h0106);
      check("t6_drop", {16'd0, drop_count}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
